// File: rtl/pulse_generator_pkg.sv
// Shared types and default widths for the burst pulse generator.
package pulse_generator_pkg;

   localparam int unsigned LEN_W_DEF = 8;
   localparam int unsigned CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } state_e;

endpackage

// File: rtl/pulse_generator_if.sv
// Trigger/configuration/waveform bundle between a controller (master) and the generator (slave).
interface pulse_generator_if import pulse_generator_pkg::*; #(
   parameter int unsigned LEN_W = LEN_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) ();

   logic             trig;
   logic [LEN_W-1:0] high_len;
   logic [LEN_W-1:0] low_len;
   logic [CNT_W-1:0] pulse_cnt;
   logic             pulse_out;
   logic             busy;
   logic             done;

   modport master (
      output trig, high_len, low_len, pulse_cnt,
      input  pulse_out, busy, done
   );

   modport slave (
      input  trig, high_len, low_len, pulse_cnt,
      output pulse_out, busy, done
   );

endinterface

// File: rtl/pulse_len_counter.sv
// Loadable down-counter for phase timing; saturates at zero instead of wrapping.
module pulse_len_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_generator.sv
// Burst pulse generator: on an accepted trig emits pulse_cnt high pulses separated by low gaps,
// then a one-cycle done strobe. All outputs are registered from the next state.
module pulse_generator import pulse_generator_pkg::*; #(
   parameter int unsigned LEN_W = LEN_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   pulse_generator_if.slave bus
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] high_q, low_q;
   logic [CNT_W-1:0] pcnt_q;
   logic             pulse_q, busy_q, done_q;

   logic             accept, pulse_end;
   logic             len_ld, len_dec, len_zero;
   logic [LEN_W-1:0] len_ld_val;

   // The counter holds "cycles remaining minus one", so a phase ends on the cycle it reads zero.
   pulse_len_counter #(.W(LEN_W)) u_len_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (len_ld),
      .load_val_i (len_ld_val),
      .dec_i      (len_dec),
      .zero_o     (len_zero)
   );

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      pulse_end  = 1'b0;
      len_ld     = 1'b0;
      len_dec    = 1'b0;
      len_ld_val = '0;
      case (state_q)
         IDLE: begin
            if (bus.trig && (bus.high_len != '0) && (bus.pulse_cnt != '0)) begin
               accept     = 1'b1;
               state_d    = HIGH;
               len_ld     = 1'b1;
               len_ld_val = bus.high_len - LEN_W'(1);
            end
         end
         HIGH: begin
            if (len_zero) begin
               pulse_end = 1'b1;
               len_ld    = 1'b1;
               if (pcnt_q == CNT_W'(1)) begin
                  state_d = FIN;
               end else begin
                  // A zero low length still gives one low cycle between pulses.
                  state_d    = LOW;
                  len_ld_val = (low_q == '0) ? '0 : low_q - LEN_W'(1);
               end
            end else begin
               len_dec = 1'b1;
            end
         end
         LOW: begin
            if (len_zero) begin
               state_d    = HIGH;
               len_ld     = 1'b1;
               len_ld_val = high_q - LEN_W'(1);
            end else begin
               len_dec = 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         high_q  <= '0;
         low_q   <= '0;
         pcnt_q  <= '0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            high_q <= bus.high_len;
            low_q  <= bus.low_len;
            pcnt_q <= bus.pulse_cnt;
         end else if (pulse_end) begin
            pcnt_q <= pcnt_q - CNT_W'(1);
         end
         pulse_q <= (state_d == HIGH);
         busy_q  <= (state_d == HIGH) || (state_d == LOW);
         done_q  <= (state_d == FIN);
      end
   end

   assign bus.pulse_out = pulse_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: hand-written waveforms sampled 1ns after each rising edge.
module tb_pulse_generator;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   pulse_generator_if #(.LEN_W(8), .CNT_W(4)) bus ();

   pulse_generator #(.LEN_W(8), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present config with a one-cycle trig; returns 1ns after the sampling edge.
   task automatic trigger(input logic [7:0] h, input logic [7:0] l, input logic [3:0] c);
      @(negedge clk);
      bus.high_len  = h;
      bus.low_len   = l;
      bus.pulse_cnt = c;
      bus.trig      = 1'b1;
      tick();
      bus.trig = 1'b0;
   endtask

   // Bit i of each vector is the expected output at sample i (sample 0 is right after the trig edge).
   // With perturb set, trig and junk config are thrown at the design mid-burst and in FIN.
   task automatic expect_seq(input string tag, input int n, input logic [15:0] p,
                             input logic [15:0] b, input logic [15:0] d, input bit perturb);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s.pulse[%0d]", tag, i), {31'd0, bus.pulse_out}, {31'd0, p[i]});
         chk($sformatf("%s.busy[%0d]", tag, i), {31'd0, bus.busy}, {31'd0, b[i]});
         chk($sformatf("%s.done[%0d]", tag, i), {31'd0, bus.done}, {31'd0, d[i]});
         if (i == n - 1) break;
         @(negedge clk);
         if (perturb && (i == 1 || i == 4 || i == 6 || i == 8)) begin
            bus.trig      = 1'b1;
            bus.high_len  = 8'($urandom_range(1, 20));
            bus.low_len   = 8'($urandom_range(0, 20));
            bus.pulse_cnt = 4'($urandom_range(1, 15));
         end else begin
            bus.trig = 1'b0;
         end
         tick();
      end
      bus.trig = 1'b0;
   endtask

   initial begin
      int hi_cnt;
      rst           = 1'b1;
      bus.trig      = 1'b0;
      bus.high_len  = '0;
      bus.low_len   = '0;
      bus.pulse_cnt = '0;
      #12;
      chk("reset.pulse", {31'd0, bus.pulse_out}, 32'd0);
      chk("reset.busy",  {31'd0, bus.busy},      32'd0);
      chk("reset.done",  {31'd0, bus.done},      32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // h=3 l=2 c=2: 111 00 111 then done, then idle.
      trigger(8'd3, 8'd2, 4'd2);
      expect_seq("basic", 10, 16'b0011100111, 16'b0011111111, 16'b0100000000, 1'b0);

      // Rejected triggers: zero high length or zero pulse count.
      trigger(8'd0, 8'd2, 4'd3);
      expect_seq("zero_high", 3, 16'b0, 16'b0, 16'b0, 1'b0);
      trigger(8'd3, 8'd2, 4'd0);
      expect_seq("zero_cnt", 3, 16'b0, 16'b0, 16'b0, 1'b0);

      // low_len=0 acts as one low cycle.
      trigger(8'd1, 8'd0, 4'd3);
      expect_seq("low0", 7, 16'b0010101, 16'b0011111, 16'b0100000, 1'b0);

      // Retriggers and config changes mid-burst and in FIN leave the waveform untouched.
      trigger(8'd3, 8'd2, 4'd2);
      expect_seq("perturb", 10, 16'b0011100111, 16'b0011111111, 16'b0100000000, 1'b1);

      // Trig in IDLE right after FIN is accepted.
      trigger(8'd1, 8'd5, 4'd1);
      expect_seq("b2b_a", 3, 16'b001, 16'b001, 16'b010, 1'b0);
      trigger(8'd2, 8'd5, 4'd1);
      expect_seq("b2b_b", 4, 16'b0011, 16'b0011, 16'b0100, 1'b0);

      // Reset during the second pulse's high phase aborts at once with no done.
      trigger(8'd3, 8'd2, 4'd2);
      expect_seq("pre_rst", 6, 16'b100111, 16'b111111, 16'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_async.pulse", {31'd0, bus.pulse_out}, 32'd0);
      chk("rst_async.busy",  {31'd0, bus.busy},      32'd0);
      chk("rst_async.done",  {31'd0, bus.done},      32'd0);
      tick();
      tick();
      chk("rst_hold.done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst.done", {31'd0, bus.done}, 32'd0);
      trigger(8'd3, 8'd2, 4'd2);
      expect_seq("post_rst", 10, 16'b0011100111, 16'b0011111111, 16'b0100000000, 1'b0);

      // Maximum high length: exactly 255 high cycles then done.
      trigger(8'd255, 8'd0, 4'd1);
      hi_cnt = 0;
      for (int i = 0; i < 300 && bus.pulse_out === 1'b1; i++) begin
         hi_cnt++;
         tick();
      end
      chk("max_len.count", 32'(hi_cnt), 32'd255);
      chk("max_len.done",  {31'd0, bus.done}, 32'd1);
      chk("max_len.busy",  {31'd0, bus.busy}, 32'd0);
      tick();
      chk("max_len.idle_done", {31'd0, bus.done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
